// File: rtl/object_placer_pkg.sv
// Shared state encoding, LFSR polynomial and range-mapping helper for the
// level object placer.
package placer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } placer_state_t;

    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Multiply-high mapping of a 16-bit random value onto [0, span).
    function automatic logic [31:0] scale16(input logic [15:0] r, input logic [31:0] span);
        return 32'((48'(r) * 48'(span)) >> 16);
    endfunction

endpackage

// File: rtl/object_placer_lfsr32.sv
// Free-running 32-bit Galois LFSR; a zero seed is replaced by 1 so the
// register can never lock up.
module lfsr32
    import placer_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [31:0] q
);

    localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] q_d;
    logic [31:0] q_q;

    always_comb begin
        q_d = {1'b0, q_q[31:1]} ^ (q_q[0] ? LFSR_TAPS : 32'd0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) q_q <= SEED_NZ;
        else          q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/object_placer.sv
// Places N_OBJ objects at pseudo-random coordinates inside per-object ranges,
// re-drawing candidates that land too close to an already placed object.
//
// state | meaning
// IDLE  | waiting for a rising edge on start
// DRAW  | register candidate (cx, cy) for object idx
// CHECK | compare candidate against all placed objects, commit or retry
// DONE  | one-cycle done pulse, then back to IDLE
module object_placer
    import placer_pkg::*;
#(
    parameter int          N_OBJ   = 18,
    parameter int          CW      = 10,
    parameter int          MIN_SEP = 24,
    parameter int          MAX_TRY = 7,
    parameter logic [31:0] SEED    = 32'hACE1_2468
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  start,
    input  logic [N_OBJ*CW-1:0]   x_lo,
    input  logic [N_OBJ*CW-1:0]   x_span,
    input  logic [N_OBJ*CW-1:0]   y_lo,
    input  logic [N_OBJ*CW-1:0]   y_span,
    output logic [N_OBJ*CW-1:0]   obj_x,
    output logic [N_OBJ*CW-1:0]   obj_y,
    output logic [N_OBJ-1:0]      obj_valid,
    output logic [N_OBJ-1:0]      obj_forced,
    output logic                  busy,
    output logic                  done
);

    localparam int             IW       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int             TW       = (MAX_TRY > 0) ? $clog2(MAX_TRY + 1) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_OBJ - 1);
    localparam logic [TW-1:0]  TRY_MAX  = TW'(MAX_TRY);
    localparam logic [31:0]    SEP      = 32'(MIN_SEP);

    logic [31:0]     lfsr;
    placer_state_t   state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   try_q, try_d;
    logic            start_q, start_d;
    logic [CW-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic [CW-1:0]   obj_x_q [N_OBJ];
    logic [CW-1:0]   obj_x_d [N_OBJ];
    logic [CW-1:0]   obj_y_q [N_OBJ];
    logic [CW-1:0]   obj_y_d [N_OBJ];
    logic [N_OBJ-1:0] valid_q, valid_d, forced_q, forced_d, hit;
    logic            busy_q, busy_d, done_q, done_d;
    logic            collide;

    logic [CW-1:0]   x_lo_a [N_OBJ];
    logic [CW-1:0]   x_sp_a [N_OBJ];
    logic [CW-1:0]   y_lo_a [N_OBJ];
    logic [CW-1:0]   y_sp_a [N_OBJ];

    lfsr32 #(.SEED(SEED)) u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .q       (lfsr)
    );

    // One separation comparator per placed slot, all evaluated in CHECK.
    for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
        logic [CW-1:0] dx, dy;
        assign x_lo_a[i] = x_lo[i*CW +: CW];
        assign x_sp_a[i] = x_span[i*CW +: CW];
        assign y_lo_a[i] = y_lo[i*CW +: CW];
        assign y_sp_a[i] = y_span[i*CW +: CW];
        assign obj_x[i*CW +: CW] = obj_x_q[i];
        assign obj_y[i*CW +: CW] = obj_y_q[i];
        assign dx = (cx_q >= obj_x_q[i]) ? cx_q - obj_x_q[i] : obj_x_q[i] - cx_q;
        assign dy = (cy_q >= obj_y_q[i]) ? cy_q - obj_y_q[i] : obj_y_q[i] - cy_q;
        assign hit[i] = valid_q[i] && (32'(dx) < SEP) && (32'(dy) < SEP);
    end

    assign collide = |hit;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        try_d    = try_q;
        start_d  = start;
        cx_d     = cx_q;
        cy_d     = cy_q;
        obj_x_d  = obj_x_q;
        obj_y_d  = obj_y_q;
        valid_d  = valid_q;
        forced_d = forced_q;
        case (state_q)
            IDLE: begin
                if (start && !start_q) begin
                    valid_d  = '0;
                    forced_d = '0;
                    idx_d    = '0;
                    try_d    = '0;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                cx_d    = CW'(32'(x_lo_a[idx_q]) + scale16(lfsr[31:16], 32'(x_sp_a[idx_q])));
                cy_d    = CW'(32'(y_lo_a[idx_q]) + scale16(lfsr[15:0], 32'(y_sp_a[idx_q])));
                state_d = CHECK;
            end
            CHECK: begin
                if (!collide || try_q == TRY_MAX) begin
                    obj_x_d[idx_q]  = cx_q;
                    obj_y_d[idx_q]  = cy_q;
                    valid_d[idx_q]  = 1'b1;
                    forced_d[idx_q] = collide;
                    try_d           = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = DRAW;
                    end
                end else begin
                    try_d   = try_q + 1'b1;
                    state_d = DRAW;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            try_q    <= '0;
            start_q  <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            obj_x_q  <= '{default: '0};
            obj_y_q  <= '{default: '0};
            valid_q  <= '0;
            forced_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            try_q    <= try_d;
            start_q  <= start_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            obj_x_q  <= obj_x_d;
            obj_y_q  <= obj_y_d;
            valid_q  <= valid_d;
            forced_q <= forced_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign obj_valid  = valid_q;
    assign obj_forced = forced_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
